// File: rtl/memory_access_if.sv
// memory_access_pkg / memory_access_if
// Payload types and the bundled port interface for the memory stage.
//   dataE     : execute -> memory bundle (address, store data, control)
//   in_ready  : memory stage can accept dataE this cycle
//   dataM     : memory -> writeback bundle (result, status flags)
//   out_ready : writeback accepts dataM this cycle
//   dreq      : data bus request (valid, addr, size, strobe, data)
//   dresp     : data bus response (addr_ok, data_ok, data)
// The master modport is the memory stage itself (it masters the data bus);
// the slave modport is the surrounding pipeline / bus environment.

package memory_access_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic   memread;
    logic   memwrite;
    msize_t msize;
    logic   mem_unsigned;
  } mem_ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic [63:0] alu_out;
    logic [63:0] memdata;
    mem_ctl_t    ctl;
    logic [4:0]  dst;
    logic        valid;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic [63:0] result;
    mem_ctl_t    ctl;
    logic [4:0]  dst;
    logic        valid;
    logic        misaligned;
    logic        bus_err;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

interface memory_access_if;
  import memory_access_pkg::*;

  execute_data_t dataE;
  logic          in_ready;
  memory_data_t  dataM;
  logic          out_ready;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;

  modport master (
    input  dataE,
    output in_ready,
    output dataM,
    input  out_ready,
    output dreq,
    input  dresp
  );

  modport slave (
    output dataE,
    input  in_ready,
    input  dataM,
    output out_ready,
    input  dreq,
    output dresp
  );

endinterface

// File: rtl/memory_access.sv
// memory_access
// Memory stage of the 5-stage RV64 pipeline. Accepts an execute bundle,
// performs at most one load/store on the data bus, and hands the result to
// writeback. Upstream is held off (in_ready=0) while a bus access is pending.
// Ports:
//   clk, reset : pipeline clock, synchronous active-high reset
//   bus        : memory_access_if.master (dataE/in_ready, dataM/out_ready,
//                dreq/dresp)
// Parameter DBUS_TIMEOUT: REQ cycles before giving up with bus_err (0 = never).
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and
// complete immediately with misaligned=1 and result = faulting address.

module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned DBUS_TIMEOUT = 0
) (
  input logic             clk,
  input logic             reset,
  memory_access_if.master bus
);

  localparam int unsigned CntW        = (DBUS_TIMEOUT > 2) ? $clog2(DBUS_TIMEOUT) : 1;
  localparam int unsigned TimeoutLast = (DBUS_TIMEOUT > 0) ? DBUS_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state;
  memory_data_t    dataMQ;
  dbus_req_t       dreqQ;
  logic [2:0]      addrLo;
  logic [CntW-1:0] toCnt;

  logic            accept;
  logic            launchMem;
  logic            misAcc;
  dbus_req_t       launchReq;
  memory_data_t    launchM;
  logic            unusedAddrOk;

  // addr_ok carries no control meaning for this stage
  assign unusedAddrOk = bus.dresp.addr_ok;

  assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept       = bus.dataE.valid && bus.in_ready;
  assign bus.dataM    = dataMQ;
  assign bus.dreq     = dreqQ;

  // Byte-lane mask for an access of the given size at byte offset 0
  function automatic logic [7:0] baseStrobe(input msize_t sz);
    case (sz)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Align the returned doubleword to bit 0, then sign/zero extend
  function automatic logic [63:0] extendLoad(input logic [63:0] raw, input logic [2:0] lo,
                                             input msize_t sz, input logic uns);
    logic [63:0] sh;
    sh = raw >> {lo, 3'b000};
    case (sz)
      MSIZE1:  return uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      MSIZE2:  return uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      MSIZE4:  return uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic isMisaligned(input msize_t sz, input logic [2:0] lo);
    case (sz)
      MSIZE1:  return 1'b0;
      MSIZE2:  return lo[0];
      MSIZE4:  return lo[1:0] != 2'b00;
      default: return lo != 3'b000;
    endcase
  endfunction
`endif

  // What a newly accepted bundle turns into: a bus request or an immediate result
  always_comb begin
    misAcc    = 1'b0;
    launchReq = '0;
    launchM   = '0;
`ifdef MEM_MISALIGN_TRAP_EN
    misAcc = (bus.dataE.ctl.memread || bus.dataE.ctl.memwrite) &&
             isMisaligned(bus.dataE.ctl.msize, bus.dataE.alu_out[2:0]);
`endif
    launchMem = (bus.dataE.ctl.memread || bus.dataE.ctl.memwrite) && !misAcc;

    launchReq.valid = 1'b1;
    launchReq.addr  = bus.dataE.alu_out;
    launchReq.size  = bus.dataE.ctl.msize;
    if (bus.dataE.ctl.memwrite) begin
      launchReq.strobe = 8'(baseStrobe(bus.dataE.ctl.msize) << bus.dataE.alu_out[2:0]);
      launchReq.data   = bus.dataE.memdata << {bus.dataE.alu_out[2:0], 3'b000};
    end

    launchM.pc         = bus.dataE.pc;
    launchM.raw_instr  = bus.dataE.raw_instr;
    launchM.ctl        = bus.dataE.ctl;
    launchM.dst        = bus.dataE.dst;
    launchM.result     = bus.dataE.alu_out;
    launchM.valid      = !launchMem;
    launchM.misaligned = misAcc;
    launchM.bus_err    = 1'b0;
  end

  // Stage FSM; accept is only possible in IDLE or in DONE with out_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      dataMQ <= '0;
      dreqQ  <= '0;
      addrLo <= '0;
      toCnt  <= '0;
    end else if (accept) begin
      state  <= launchMem ? REQ : DONE;
      dataMQ <= launchM;
      addrLo <= bus.dataE.alu_out[2:0];
      toCnt  <= '0;
      if (launchMem) dreqQ <= launchReq;
    end else begin
      case (state)
        REQ: begin
          if (bus.dresp.data_ok) begin
            // data_ok takes priority over a coincident timeout
            dreqQ.valid    <= 1'b0;
            dataMQ.valid   <= 1'b1;
            dataMQ.result  <= dataMQ.ctl.memread
                              ? extendLoad(bus.dresp.data, addrLo, dataMQ.ctl.msize,
                                           dataMQ.ctl.mem_unsigned)
                              : 64'd0;
            toCnt          <= '0;
            state          <= DONE;
          end else if ((DBUS_TIMEOUT != 0) && (toCnt == CntW'(TimeoutLast))) begin
            dreqQ.valid    <= 1'b0;
            dataMQ.valid   <= 1'b1;
            dataMQ.result  <= 64'd0;
            dataMQ.bus_err <= 1'b1;
            toCnt          <= '0;
            state          <= DONE;
          end else begin
            toCnt <= toCnt + CntW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            dataMQ.valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access
// Directed bench for memory_access: instance A (no timeout) covers pass-through,
// loads, stores and backpressure; instance B (DBUS_TIMEOUT=4) covers timeout,
// data_ok-vs-timeout priority and reset during a pending request.

module tb_memory_access;
  import memory_access_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  memory_access_if ifA ();
  memory_access_if ifB ();

  memory_access #(.DBUS_TIMEOUT(0)) u_dutA (.clk(clk), .reset(reset), .bus(ifA));
  memory_access #(.DBUS_TIMEOUT(4)) u_dutB (.clk(clk), .reset(reset), .bus(ifB));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic execute_data_t mkE(input logic [63:0] pc, input logic [63:0] addr,
                                        input logic [63:0] wdata, input logic rd,
                                        input logic wr, input msize_t sz, input logic uns);
    execute_data_t e;
    e = '0;
    e.pc               = pc;
    e.raw_instr        = 32'h0000_0013;
    e.alu_out          = addr;
    e.memdata          = wdata;
    e.ctl.memread      = rd;
    e.ctl.memwrite     = wr;
    e.ctl.msize        = sz;
    e.ctl.mem_unsigned = uns;
    e.dst              = 5'd10;
    e.valid            = 1'b1;
    return e;
  endfunction

  // One load/store on instance A with out_ready=1
  task automatic memOp(input string tag, input execute_data_t e, input int waits,
                       input logic [63:0] rdata, input logic [7:0] expStrb,
                       input logic [63:0] expData, input logic [63:0] expRes);
    ifA.dataE = e;
    step();
    ifA.dataE.valid = 1'b0;
    chk({tag, ".reqValid"}, 64'(ifA.dreq.valid), 64'd1);
    chk({tag, ".addr"}, ifA.dreq.addr, e.alu_out);
    chk({tag, ".size"}, 64'(ifA.dreq.size), 64'(e.ctl.msize));
    chk({tag, ".strobe"}, 64'(ifA.dreq.strobe), 64'(expStrb));
    chk({tag, ".wdata"}, ifA.dreq.data, expData);
    chk({tag, ".inReady"}, 64'(ifA.in_ready), 64'd0);
    chk({tag, ".mValidPend"}, 64'(ifA.dataM.valid), 64'd0);
    for (int i = 0; i < waits; i++) begin
      step();
      chk({tag, ".holdValid"}, 64'(ifA.dreq.valid), 64'd1);
      chk({tag, ".holdStrobe"}, 64'(ifA.dreq.strobe), 64'(expStrb));
      chk({tag, ".holdData"}, ifA.dreq.data, expData);
      chk({tag, ".holdInReady"}, 64'(ifA.in_ready), 64'd0);
    end
    ifA.dresp.data_ok = 1'b1;
    ifA.dresp.data    = rdata;
    step();
    ifA.dresp.data_ok = 1'b0;
    ifA.dresp.data    = '0;
    chk({tag, ".mValid"}, 64'(ifA.dataM.valid), 64'd1);
    chk({tag, ".result"}, ifA.dataM.result, expRes);
    chk({tag, ".busErr"}, 64'(ifA.dataM.bus_err), 64'd0);
    chk({tag, ".misaligned"}, 64'(ifA.dataM.misaligned), 64'd0);
    chk({tag, ".pc"}, ifA.dataM.pc, e.pc);
    chk({tag, ".dst"}, 64'(ifA.dataM.dst), 64'd10);
    chk({tag, ".reqDrop"}, 64'(ifA.dreq.valid), 64'd0);
    step();
    chk({tag, ".idle"}, 64'(ifA.dataM.valid), 64'd0);
  endtask

  initial begin
    ifA.dataE = '0; ifA.out_ready = 1'b1; ifA.dresp = '0;
    ifB.dataE = '0; ifB.out_ready = 1'b1; ifB.dresp = '0;
    reset = 1'b1;
    step();
    step();
    chk("rst.mValid", 64'(ifA.dataM.valid), 64'd0);
    chk("rst.result", ifA.dataM.result, 64'd0);
    chk("rst.reqValid", 64'(ifA.dreq.valid), 64'd0);
    chk("rst.reqAddr", ifA.dreq.addr, 64'd0);
    chk("rst.inReady", 64'(ifA.in_ready), 64'd1);
    reset = 1'b0;
    step();

    // Back-to-back non-memory ops
    for (int i = 0; i < 3; i++) begin
      ifA.dataE = mkE(64'h100 + 64'(4 * i), 64'h1234 + 64'(i) * 64'h4444, 64'd0,
                      1'b0, 1'b0, MSIZE8, 1'b0);
      #1;
      chk("alu.inReady", 64'(ifA.in_ready), 64'd1);
      step();
      chk("alu.mValid", 64'(ifA.dataM.valid), 64'd1);
      chk("alu.result", ifA.dataM.result, 64'h1234 + 64'(i) * 64'h4444);
      chk("alu.noReq", 64'(ifA.dreq.valid), 64'd0);
    end
    ifA.dataE.valid = 1'b0;
    step();
    chk("alu.idle", 64'(ifA.dataM.valid), 64'd0);

    // Loads
    memOp("LB", mkE(64'h200, 64'h8000_0003, 64'd0, 1'b1, 1'b0, MSIZE1, 1'b0), 2,
          64'h0000_0000_8000_0000, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF80);
    memOp("LBU", mkE(64'h204, 64'h8000_0003, 64'd0, 1'b1, 1'b0, MSIZE1, 1'b1), 2,
          64'h0000_0000_8000_0000, 8'h00, 64'd0, 64'h0000_0000_0000_0080);
    memOp("LH", mkE(64'h208, 64'h3002, 64'd0, 1'b1, 1'b0, MSIZE2, 1'b0), 0,
          64'h0000_0000_9ABC_0000, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_9ABC);
    memOp("LWU", mkE(64'h20C, 64'h3004, 64'd0, 1'b1, 1'b0, MSIZE4, 1'b1), 1,
          64'h8765_4321_0000_0000, 8'h00, 64'd0, 64'h0000_0000_8765_4321);
    memOp("LD", mkE(64'h210, 64'h3008, 64'd0, 1'b1, 1'b0, MSIZE8, 1'b0), 1,
          64'h0123_4567_89AB_CDEF, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF);

    // Stores
    memOp("SH", mkE(64'h214, 64'h8000_0006, 64'hABCD, 1'b0, 1'b1, MSIZE2, 1'b0), 4,
          64'hDEAD, 8'hC0, 64'hABCD_0000_0000_0000, 64'd0);
    memOp("SB", mkE(64'h218, 64'h1007, 64'h5A, 1'b0, 1'b1, MSIZE1, 1'b0), 0,
          64'd0, 8'h80, 64'h5A00_0000_0000_0000, 64'd0);
    memOp("SW", mkE(64'h21C, 64'h100C, 64'hCAFE_BABE, 1'b0, 1'b1, MSIZE4, 1'b0), 1,
          64'd0, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'd0);
    memOp("SD", mkE(64'h220, 64'h1008, 64'h1122_3344_5566_7788, 1'b0, 1'b1, MSIZE8, 1'b0), 1,
          64'd0, 8'hFF, 64'h1122_3344_5566_7788, 64'd0);

    // Misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    ifA.dataE = mkE(64'h224, 64'h8000_0002, 64'd0, 1'b1, 1'b0, MSIZE4, 1'b0);
    step();
    ifA.dataE.valid = 1'b0;
    chk("mis.noReq", 64'(ifA.dreq.valid), 64'd0);
    chk("mis.mValid", 64'(ifA.dataM.valid), 64'd1);
    chk("mis.flag", 64'(ifA.dataM.misaligned), 64'd1);
    chk("mis.result", ifA.dataM.result, 64'h8000_0002);
    step();
    chk("mis.idle", 64'(ifA.dataM.valid), 64'd0);
`else
    memOp("LWmis", mkE(64'h224, 64'h8000_0002, 64'd0, 1'b1, 1'b0, MSIZE4, 1'b0), 0,
          64'h0000_0000_1234_5678, 8'h00, 64'd0, 64'h0000_0000_0000_1234);
`endif

    // Load completes under backpressure, queued op follows on release
    ifA.out_ready = 1'b0;
    ifA.dataE = mkE(64'h300, 64'h3010, 64'd0, 1'b1, 1'b0, MSIZE8, 1'b0);
    step();
    chk("bp.reqValid", 64'(ifA.dreq.valid), 64'd1);
    ifA.dataE = mkE(64'h304, 64'h77, 64'd0, 1'b0, 1'b0, MSIZE8, 1'b0);
    ifA.dresp.data_ok = 1'b1;
    ifA.dresp.data    = 64'hFEDC_BA98_7654_3210;
    step();
    ifA.dresp.data_ok = 1'b0;
    ifA.dresp.data    = '0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) step();
      #1;
      chk("bp.mValid", 64'(ifA.dataM.valid), 64'd1);
      chk("bp.result", ifA.dataM.result, 64'hFEDC_BA98_7654_3210);
      chk("bp.inReady", 64'(ifA.in_ready), 64'd0);
    end
    ifA.out_ready = 1'b1;
    #1;
    chk("bp.release", 64'(ifA.in_ready), 64'd1);
    step();
    ifA.dataE.valid = 1'b0;
    chk("bp.nextValid", 64'(ifA.dataM.valid), 64'd1);
    chk("bp.nextResult", ifA.dataM.result, 64'h77);
    chk("bp.nextPc", ifA.dataM.pc, 64'h304);
    step();
    chk("bp.idle", 64'(ifA.dataM.valid), 64'd0);

    // Timeout after exactly 4 REQ cycles
    ifB.dataE = mkE(64'h400, 64'h2000, 64'd0, 1'b1, 1'b0, MSIZE4, 1'b0);
    step();
    ifB.dataE.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to.reqValid", 64'(ifB.dreq.valid), 64'd1);
      chk("to.pending", 64'(ifB.dataM.valid), 64'd0);
      step();
    end
    chk("to.reqDrop", 64'(ifB.dreq.valid), 64'd0);
    chk("to.mValid", 64'(ifB.dataM.valid), 64'd1);
    chk("to.busErr", 64'(ifB.dataM.bus_err), 64'd1);
    chk("to.result", ifB.dataM.result, 64'd0);
    step();
    chk("to.idle", 64'(ifB.dataM.valid), 64'd0);

    // data_ok in the expiry cycle wins
    ifB.dataE = mkE(64'h404, 64'h2000, 64'd0, 1'b1, 1'b0, MSIZE4, 1'b0);
    step();
    ifB.dataE.valid = 1'b0;
    step();
    step();
    step();
    chk("tie.reqValid", 64'(ifB.dreq.valid), 64'd1);
    ifB.dresp.data_ok = 1'b1;
    ifB.dresp.data    = 64'h0000_0000_8000_0001;
    step();
    ifB.dresp.data_ok = 1'b0;
    ifB.dresp.data    = '0;
    chk("tie.mValid", 64'(ifB.dataM.valid), 64'd1);
    chk("tie.busErr", 64'(ifB.dataM.bus_err), 64'd0);
    chk("tie.result", ifB.dataM.result, 64'hFFFF_FFFF_8000_0001);
    step();

    // Reset during REQ discards the access
    ifB.dataE = mkE(64'h408, 64'h2008, 64'd0, 1'b1, 1'b0, MSIZE4, 1'b0);
    step();
    ifB.dataE.valid = 1'b0;
    step();
    chk("rq.reqValid", 64'(ifB.dreq.valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rq.reqDrop", 64'(ifB.dreq.valid), 64'd0);
    chk("rq.mValid", 64'(ifB.dataM.valid), 64'd0);
    chk("rq.inReady", 64'(ifB.in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rq.noOutput", 64'(ifB.dataM.valid), 64'd0);
      chk("rq.noReq", 64'(ifB.dreq.valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the 5-stage RV64 pipeline.
- Consumes the execute_data_t bundle produced by the execute stage and performs loads and stores over the data bus (dbus_req_t / dbus_resp_t).
- Produces memory_data_t for writeback.
- Holds upstream via in_ready while a bus transaction is outstanding.

Parameters:
- DBUS_TIMEOUT, 0, cycles to wait for data_ok before raising bus_err; 0 disables the timeout.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- dataE  input  execute_data_t  bundle from execute: pc, raw_instr, alu_out (effective address or ALU result), memdata (store data, rs2), ctl (memread, memwrite, msize, mem_unsigned), dst, valid
- in_ready  output  1  stage can accept dataE this cycle
- dataM  output  memory_data_t  pc, raw_instr, result, ctl, dst, valid, misaligned, bus_err
- out_ready  input  1  writeback accepts dataM this cycle
- dreq  output  dbus_req_t  valid, addr[63:0], size (MSIZE1/2/4/8), strobe[7:0], data[63:0]
- dresp  input  dbus_resp_t  addr_ok, data_ok, data[63:0]

Behaviour:
- Reset values: state=IDLE, dataM all zero (valid=0), dreq all zero, in_ready=1, timeout counter=0.
- Accept condition: dataE.valid && in_ready. The accepted bundle is captured into an internal register.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue with no bubble for non-memory ops.
- States:
  - IDLE: on accept, go to REQ if ctl.memread or ctl.memwrite (and the access is not suppressed, see Optional Feature); otherwise go to DONE with result=alu_out.
  - REQ: dreq.valid=1. dreq fields are registered and held stable until data_ok. addr_ok is ignored for control.
    - dresp.data_ok -> DONE. For a load, result=extend(dresp.data >> 8*addr[2:0]) per msize and mem_unsigned. For a store, result=0.
  - DONE: dataM.valid=1, fields held while out_ready=0. When out_ready=1: if a new bundle is accepted the same cycle, transition as from IDLE; otherwise go to IDLE.
- Latency: non-memory ops appear on dataM 1 cycle after accept. Memory ops appear 1 cycle after the data_ok cycle.
- dreq.valid drops in the cycle after data_ok.
- Address and data: dreq.addr=alu_out (full 64 bits).
  - Store strobe: MSIZE1 8'h01, MSIZE2 8'h03, MSIZE4 8'h0F, MSIZE8 8'hFF, each shifted left by addr[2:0].
  - Store data: memdata shifted left by 8*addr[2:0].
  - Loads: strobe=0.
- Extension: LB/LH/LW sign-extend bits 7/15/31; LBU/LHU/LWU zero-extend; LD is unmodified.
- Bubble input (dataE.valid=0): not accepted, no state change.
- Timeout (DBUS_TIMEOUT>0):
  - The counter increments each cycle in REQ.
  - When it reaches DBUS_TIMEOUT: drop dreq.valid, go to DONE with bus_err=1 and result=0.
  - The counter clears on leaving REQ.
- data_ok in the same cycle as the timeout expiry: data_ok wins, bus_err=0.
- Reset mid-transaction: state returns to IDLE and dreq.valid=0 the next cycle. The captured bundle is discarded and no dataM.valid is produced for it.
- Pass-through: pc, raw_instr, ctl and dst are copied unchanged from the captured bundle.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - An access whose addr is not a multiple of its size (MSIZE2 with addr[0]; MSIZE4 with addr[1:0]!=0; MSIZE8 with addr[2:0]!=0) issues no bus request.
  - Go directly IDLE->DONE with misaligned=1, result=alu_out (the faulting address), 1-cycle latency.
- Undefined:
  - misaligned is tied to 0.
  - The address is used as given. Shifting uses addr[2:0]; strobe bits beyond bit 7 are truncated, and dreq.data bits shifted beyond bit 63 are truncated.

Test Plan:
- Non-memory op, alu_out=64'h1234, out_ready=1 -> dataM.valid on the next cycle, result=64'h1234, no dreq.valid, in_ready stays 1 (back-to-back: 3 consecutive ops yield 3 consecutive outputs).
- LB addr=64'h8000_0003, dresp.data=64'h0000_0000_8000_0000 after 2-cycle wait -> dreq.size=MSIZE1, strobe=0, result=64'hFFFF_FFFF_FFFF_FF80. LBU with the same input gives result 64'h80.
- SH addr=64'h8000_0006, memdata=64'hABCD -> dreq.strobe=8'hC0, dreq.data[63:48]=16'hABCD, dreq held stable for 4 wait cycles; in_ready=0 until DONE.
- Load completes while out_ready=0 for 3 cycles -> dataM stays valid and unchanged, in_ready=0. Releasing out_ready passes the next queued bundle in the same cycle.
- DBUS_TIMEOUT=4, no data_ok -> dreq.valid high for exactly 4 cycles, then dataM.valid with bus_err=1. A reset asserted during REQ clears dreq.valid and produces no output.
- With MEM_MISALIGN_TRAP_EN: LW addr=64'h8000_0002 -> no dreq.valid, dataM.misaligned=1, result=64'h8000_0002 after 1 cycle.
